// File: rtl/digit_match_pkg.sv
// Shared constants, FSM state encoding and the stored digit templates used by
// the nearest-template digit matcher.
package digit_match_pkg;

    localparam int TMPL_W       = 11;
    localparam int TMPL_H       = 11;
    localparam int TMPL_PIX_W   = 8;
    localparam int TMPL_CLASSES = 10;
    localparam int NUM_PIX      = TMPL_W * TMPL_H;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef logic [TMPL_CLASSES-1:0][NUM_PIX-1:0][TMPL_PIX_W-1:0] tmpl_arr_t;

    // One row per entry, bit TMPL_W-1 is the leftmost column; set bits are full-scale ink.
    localparam logic [TMPL_W-1:0] GLYPHS [TMPL_CLASSES][TMPL_H] = '{
        '{11'h000, 11'h1FC, 11'h104, 11'h104, 11'h104, 11'h104, 11'h104, 11'h104, 11'h104, 11'h1FC, 11'h000},
        '{11'h000, 11'h020, 11'h060, 11'h0A0, 11'h020, 11'h020, 11'h020, 11'h020, 11'h020, 11'h1FC, 11'h000},
        '{11'h000, 11'h1FC, 11'h004, 11'h004, 11'h004, 11'h1FC, 11'h100, 11'h100, 11'h100, 11'h1FC, 11'h000},
        '{11'h000, 11'h1FC, 11'h004, 11'h004, 11'h004, 11'h1FC, 11'h004, 11'h004, 11'h004, 11'h1FC, 11'h000},
        '{11'h000, 11'h104, 11'h104, 11'h104, 11'h104, 11'h1FC, 11'h004, 11'h004, 11'h004, 11'h004, 11'h000},
        '{11'h000, 11'h1FC, 11'h100, 11'h100, 11'h100, 11'h1FC, 11'h004, 11'h004, 11'h004, 11'h1FC, 11'h000},
        '{11'h000, 11'h1FC, 11'h100, 11'h100, 11'h100, 11'h1FC, 11'h104, 11'h104, 11'h104, 11'h1FC, 11'h000},
        '{11'h000, 11'h1FC, 11'h004, 11'h008, 11'h010, 11'h020, 11'h040, 11'h040, 11'h040, 11'h040, 11'h000},
        '{11'h000, 11'h1FC, 11'h104, 11'h104, 11'h104, 11'h1FC, 11'h104, 11'h104, 11'h104, 11'h1FC, 11'h000},
        '{11'h000, 11'h1FC, 11'h104, 11'h104, 11'h104, 11'h1FC, 11'h004, 11'h004, 11'h004, 11'h1FC, 11'h000}
    };

    function automatic tmpl_arr_t build_templates();
        tmpl_arr_t t;
        t = '0;
        for (int c = 0; c < TMPL_CLASSES; c++)
            for (int r = 0; r < TMPL_H; r++)
                for (int x = 0; x < TMPL_W; x++)
                    t[c][r*TMPL_W + x] = {TMPL_PIX_W{GLYPHS[c][r][TMPL_W-1-x]}};
        return t;
    endfunction

    localparam tmpl_arr_t TEMPLATES = build_templates();

endpackage

// File: rtl/digit_matcher_stream_if.sv
// Pixel input stream and classification result handshake of the digit matcher.
interface digit_matcher_stream_if #(
    parameter int PIX_W = 8,
    parameter int ACC_W = 23,
    parameter int CLS_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic [PIX_W-1:0] in_pix;
    logic             out_valid;
    logic             out_ready;
    logic [CLS_W-1:0] out_class;
    logic [ACC_W-1:0] out_dist;
    logic [ACC_W-1:0] out_margin;

    modport master (
        output in_valid, in_sof, in_pix, out_ready,
        input  in_ready, out_valid, out_class, out_dist, out_margin
    );

    modport slave (
        input  in_valid, in_sof, in_pix, out_ready,
        output in_ready, out_valid, out_class, out_dist, out_margin
    );
endinterface

// File: rtl/digit_template_rom.sv
// Combinational template lookup: every class's sample for one pixel position.
module digit_template_rom
    import digit_match_pkg::*;
#(
    parameter int NUM_CLASSES = TMPL_CLASSES,
    parameter int NUM_PIX     = digit_match_pkg::NUM_PIX,
    parameter int PIX_W       = TMPL_PIX_W,
    parameter int IDX_W       = $clog2(NUM_PIX),
    parameter logic [NUM_CLASSES-1:0][NUM_PIX-1:0][PIX_W-1:0] TMPL = TEMPLATES
) (
    input  logic [IDX_W-1:0]                  pix_idx,
    output logic [NUM_CLASSES-1:0][PIX_W-1:0] samples
);
    always_comb begin
        samples = '0;
        if (int'(pix_idx) < NUM_PIX)
            for (int c = 0; c < NUM_CLASSES; c++)
                samples[c] = TMPL[c][pix_idx];
    end
endmodule

// File: rtl/digit_matcher_stream.sv
// Streaming nearest-template digit classifier: parallel squared-difference
// accumulation per class, then a serial best/runner-up scan over the totals.
module digit_matcher_stream
    import digit_match_pkg::*;
#(
    parameter int IMG_W       = TMPL_W,
    parameter int IMG_H       = TMPL_H,
    parameter int PIX_W       = TMPL_PIX_W,
    parameter int NUM_CLASSES = TMPL_CLASSES,
    parameter int ACC_W       = 2*PIX_W + $clog2(IMG_W*IMG_H),
    parameter logic [NUM_CLASSES-1:0][IMG_W*IMG_H-1:0][PIX_W-1:0] TMPL = TEMPLATES
) (
    input  logic clk,
    input  logic reset,
    digit_matcher_stream_if.slave s
);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int IDX_W = $clog2(NPIX);
    localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int SQ_W  = 2 * PIX_W;

    localparam logic [1:0] ST_LOAD   = LOAD;
    localparam logic [1:0] ST_SEARCH = SEARCH;
    localparam logic [1:0] ST_DONE   = DONE;

    function automatic logic [SQ_W-1:0] sq_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
        logic signed [PIX_W:0]     d;
        logic signed [2*PIX_W+1:0] dx;
        logic signed [2*PIX_W+1:0] p;
        d  = $signed({1'b0, a}) - $signed({1'b0, b});
        dx = (2*PIX_W+2)'(d);
        p  = dx * dx;
        return p[SQ_W-1:0];
    endfunction

    logic [1:0]                     state;
    logic [IDX_W-1:0]               pix_idx;
    logic [IDX_W-1:0]               rd_idx;
    logic [CLS_W-1:0]               scan_idx;
    logic [CLS_W-1:0]               best_idx;
    logic [ACC_W-1:0]               acc [NUM_CLASSES];
    logic [ACC_W-1:0]               best;
    logic [ACC_W-1:0]               second;
    logic [ACC_W-1:0]               cur;
    logic [ACC_W-1:0]               best_n;
    logic [ACC_W-1:0]               second_n;
    logic [CLS_W-1:0]               idx_n;
    logic                           lt_best;
    logic                           lt_second;
    logic [NUM_CLASSES-1:0][PIX_W-1:0] samples;
    logic                           accept;
    logic                           sof;
    logic                           last_pix;
    logic                           scan_last;
    logic [CLS_W-1:0]               out_class_q;
    logic [ACC_W-1:0]               out_dist_q;
    logic [ACC_W-1:0]               out_margin_q;

    assign accept    = s.in_valid && (state == ST_LOAD);
    assign sof       = accept && s.in_sof;
    // A start-of-frame beat is always pixel 0, whatever the running index says.
    assign rd_idx    = s.in_sof ? '0 : pix_idx;
    assign last_pix  = (rd_idx == IDX_W'(NPIX - 1));
    assign scan_last = (scan_idx == CLS_W'(NUM_CLASSES - 1));

    digit_template_rom #(
        .NUM_CLASSES (NUM_CLASSES),
        .NUM_PIX     (NPIX),
        .PIX_W       (PIX_W),
        .IDX_W       (IDX_W),
        .TMPL        (TMPL)
    ) u_rom (
        .pix_idx (rd_idx),
        .samples (samples)
    );

    always_comb begin
        cur = '0;
        for (int c = 0; c < NUM_CLASSES; c++)
            if (scan_idx == CLS_W'(c)) cur = acc[c];
    end

    // Strict compares keep the lowest index on ties and drop the tie into second.
    assign lt_best   = (cur < best);
    assign lt_second = (cur < second);
    assign best_n    = lt_best ? cur : best;
    assign second_n  = lt_best ? best : (lt_second ? cur : second);
    assign idx_n     = lt_best ? scan_idx : best_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_LOAD;
            pix_idx      <= '0;
            scan_idx     <= '0;
            best_idx     <= '0;
            best         <= '1;
            second       <= '1;
            out_class_q  <= '0;
            out_dist_q   <= '0;
            out_margin_q <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        for (int c = 0; c < NUM_CLASSES; c++)
                            acc[c] <= (sof ? '0 : acc[c]) + ACC_W'(sq_diff(s.in_pix, samples[c]));
                        pix_idx <= last_pix ? '0 : rd_idx + IDX_W'(1);
                        if (last_pix) begin
                            state    <= ST_SEARCH;
                            scan_idx <= '0;
                            best_idx <= '0;
                            best     <= '1;
                            second   <= '1;
                        end
                    end
                end
                ST_SEARCH: begin
                    best     <= best_n;
                    second   <= second_n;
                    best_idx <= idx_n;
                    scan_idx <= scan_idx + CLS_W'(1);
                    if (scan_last) begin
                        state        <= ST_DONE;
                        out_class_q  <= idx_n;
                        out_dist_q   <= best_n;
                        out_margin_q <= second_n - best_n;
                    end
                end
                ST_DONE: begin
                    if (s.out_ready) begin
                        state   <= ST_LOAD;
                        pix_idx <= '0;
                        for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    assign s.in_ready   = (state == ST_LOAD);
    assign s.out_valid  = (state == ST_DONE);
    assign s.out_class  = out_class_q;
    assign s.out_dist   = out_dist_q;
    assign s.out_margin = out_margin_q;

endmodule

// File: tb/tb_digit_matcher_stream.sv
// Directed bench for digit_matcher_stream: exact-template frames, gaps, restart,
// saturated frame with output backpressure, tie-break and reset during search.
module tb_digit_matcher_stream;
    import digit_match_pkg::*;

    localparam int ACC_W = 2*TMPL_PIX_W + $clog2(NUM_PIX);
    localparam int CLS_W = $clog2(TMPL_CLASSES);

    function automatic tmpl_arr_t tie_templates();
        tmpl_arr_t t;
        t    = TEMPLATES;
        t[7] = t[2];
        return t;
    endfunction

    localparam tmpl_arr_t TIE_TMPL = tie_templates();

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       in_valid  = 1'b0;
    logic       in_sof    = 1'b0;
    logic [7:0] in_pix    = 8'd0;
    logic       out_ready = 1'b0;
    logic       tie_sel   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    bit seen;

    always #5 clk = ~clk;

    digit_matcher_stream_if #(.PIX_W(TMPL_PIX_W), .ACC_W(ACC_W), .CLS_W(CLS_W)) ifa ();
    digit_matcher_stream_if #(.PIX_W(TMPL_PIX_W), .ACC_W(ACC_W), .CLS_W(CLS_W)) ifb ();

    assign ifa.in_valid  = in_valid & ~tie_sel;
    assign ifa.in_sof    = in_sof;
    assign ifa.in_pix    = in_pix;
    assign ifa.out_ready = out_ready & ~tie_sel;
    assign ifb.in_valid  = in_valid & tie_sel;
    assign ifb.in_sof    = in_sof;
    assign ifb.in_pix    = in_pix;
    assign ifb.out_ready = out_ready & tie_sel;

    logic             obs_in_ready;
    logic             obs_out_valid;
    logic [CLS_W-1:0] obs_class;
    logic [ACC_W-1:0] obs_dist;
    logic [ACC_W-1:0] obs_margin;

    assign obs_in_ready  = tie_sel ? ifb.in_ready   : ifa.in_ready;
    assign obs_out_valid = tie_sel ? ifb.out_valid  : ifa.out_valid;
    assign obs_class     = tie_sel ? ifb.out_class  : ifa.out_class;
    assign obs_dist      = tie_sel ? ifb.out_dist   : ifa.out_dist;
    assign obs_margin    = tie_sel ? ifb.out_margin : ifa.out_margin;

    digit_matcher_stream dut (
        .clk   (clk),
        .reset (reset),
        .s     (ifa)
    );

    digit_matcher_stream #(.TMPL(TIE_TMPL)) dut_tie (
        .clk   (clk),
        .reset (reset),
        .s     (ifb)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int tmpl_dist(input tmpl_arr_t t, input int a, input int b);
        int s;
        int d;
        s = 0;
        for (int p = 0; p < NUM_PIX; p++) begin
            d = int'(t[a][p]) - int'(t[b][p]);
            s += d * d;
        end
        return s;
    endfunction

    function automatic int min_margin(input tmpl_arr_t t, input int ref_cls);
        int m;
        m = 32'h7fff_ffff;
        for (int c = 0; c < TMPL_CLASSES; c++)
            if (c != ref_cls && tmpl_dist(t, c, ref_cls) < m) m = tmpl_dist(t, c, ref_cls);
        return m;
    endfunction

    task automatic beat(input logic [7:0] p, input logic sof);
        @(negedge clk);
        in_valid = 1'b1;
        in_pix   = p;
        in_sof   = sof;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic send_tmpl(input int cls, input bit gaps, input bit first_sof);
        for (int p = 0; p < NUM_PIX; p++) begin
            if (gaps && p > 0 && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            beat(TEMPLATES[cls][p], first_sof && (p == 0));
        end
    endtask

    task automatic wait_result(output int cycles);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        cycles   = 0;
        while (!obs_out_valid && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic take_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_in_ready_after"}, obs_in_ready, 1);
        check_eq({tag, "_out_valid_after"}, obs_out_valid, 0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", obs_in_ready, 1);
        check_eq("rst_out_valid", obs_out_valid, 0);
        check_eq("rst_class", obs_class, 0);
        check_eq("rst_dist", obs_dist, 0);
        check_eq("rst_margin", obs_margin, 0);
        reset = 1'b0;

        // Exact class-0 frame, no gaps
        send_tmpl(0, 1'b0, 1'b1);
        wait_result(lat);
        check_eq("c0_latency", lat, 10);
        check_eq("c0_class", obs_class, 0);
        check_eq("c0_dist", obs_dist, 0);
        check_eq("c0_margin", obs_margin, min_margin(TEMPLATES, 0));
        take_result("c0");

        // Class 3 with random input gaps
        send_tmpl(3, 1'b1, 1'b1);
        wait_result(lat);
        check_eq("c3_latency", lat, 10);
        check_eq("c3_class", obs_class, 3);
        check_eq("c3_dist", obs_dist, 0);
        check_eq("c3_margin", obs_margin, min_margin(TEMPLATES, 3));
        take_result("c3");

        // Partial random frame, then restart with class 5
        for (int i = 0; i < 60; i++) beat(8'($urandom_range(0, 255)), i == 0);
        send_tmpl(5, 1'b0, 1'b1);
        wait_result(lat);
        check_eq("c5_class", obs_class, 5);
        check_eq("c5_dist", obs_dist, 0);
        check_eq("c5_margin", obs_margin, min_margin(TEMPLATES, 5));
        take_result("c5");

        // All-255 frame: digit 8 has the most ink (33 px), 6 and 9 follow with 30
        for (int p = 0; p < NUM_PIX; p++) beat(8'd255, p == 0);
        wait_result(lat);
        check_eq("sat_latency", lat, 10);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_sof    = 1'b1;
            in_pix    = 8'd0;
            out_ready = 1'b0;
            check_eq("sat_hold_in_ready", obs_in_ready, 0);
            check_eq("sat_hold_out_valid", obs_out_valid, 1);
            check_eq("sat_class", obs_class, 8);
            check_eq("sat_dist", obs_dist, 88 * 65025);
            check_eq("sat_margin", obs_margin, 3 * 65025);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("sat_in_ready_after", obs_in_ready, 1);
        check_eq("sat_out_valid_after", obs_out_valid, 0);
        @(negedge clk);
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b0;

        // Identical templates 2 and 7
        tie_sel = 1'b1;
        send_tmpl(2, 1'b0, 1'b1);
        wait_result(lat);
        check_eq("tie_class", obs_class, 2);
        check_eq("tie_dist", obs_dist, 0);
        check_eq("tie_margin", obs_margin, 0);
        take_result("tie");
        tie_sel = 1'b0;

        // Reset while the scan is running
        send_tmpl(0, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("search_in_ready", obs_in_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_out_valid", obs_out_valid, 0);
        check_eq("abort_in_ready", obs_in_ready, 1);
        check_eq("abort_dist", obs_dist, 0);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (obs_out_valid) seen = 1'b1;
        end
        check_eq("abort_no_result", seen, 0);

        // No sof on the first beat: only classifies correctly if pix_idx restarted at 0
        send_tmpl(0, 1'b0, 1'b0);
        wait_result(lat);
        check_eq("post_latency", lat, 10);
        check_eq("post_class", obs_class, 0);
        check_eq("post_dist", obs_dist, 0);
        take_result("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
